// File: rtl/gf_pkg.sv
// gf_pkg -- shared definitions for the GF(2^N) matrix-vector block.
//
// Holds the default field width and matrix geometry and the controller
// state encoding. Optional build macro: GF_MATVEC_PIPE_EN adds the DRAIN
// state used by the registered-product variant.
package gf_pkg;

    localparam int GF_N    = 8;
    localparam int GF_ROWS = 4;
    localparam int GF_COLS = 4;

`ifdef GF_MATVEC_PIPE_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_MAC    = 3'd2,
        ST_OUT    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_MAC    = 3'd2,
        ST_OUT    = 3'd3
    } state_t;
`endif

endpackage

// File: rtl/gf_mul.sv
// gf_mul -- combinational GF(2^N) multiplier.
//
// Ports:
//   a [N-1:0]  multiplicand
//   b [N-1:0]  multiplier
//   p [N:0]    reduction polynomial (p[N] expected to be 1)
//   s [N-1:0]  a*b reduced modulo p
//
// Horner-style evaluation: scan b from MSB down, doubling the running
// value (shift + conditional reduction) before adding a. This keeps the
// intermediate at N+1 bits instead of building a 2N-bit product.
module gf_mul
    import gf_pkg::*;
#(
    parameter int N = GF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N:0]   p,
    output logic [N-1:0] s
);

    logic [N:0] r;

    always_comb begin
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r = {r[N-1:0], 1'b0};
            if (r[N]) r = r ^ p;
            if (b[i]) r = r ^ {1'b0, a};
        end
        s = r[N-1:0];
    end

endmodule

// File: rtl/gf_matvec_seq.sv
// gf_matvec_seq -- sequential GF(2^N) matrix-vector product s = A*b.
//
// A job starts with a start pulse in IDLE (p is latched then). The vector
// b arrives first on the input stream (COLS elements), followed by A in
// row-major order. After each row, the row sum is offered on the output
// stream; the next row is only accepted after that result is taken.
// A single gf_mul instance serves every product.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready and out_valid are never high together, and the
// output holds out_data/out_last steady until out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a job (IDLE only)
//   p [N:0]             reduction polynomial
//   in_valid/in_ready/in_data [N-1:0]     operand stream (b, then A)
//   out_valid/out_ready/out_data [N-1:0]  result stream, out_last on row ROWS-1
//   busy                high outside IDLE
//   done                one-cycle pulse after the final output transfer
//
// Build option GF_MATVEC_PIPE_EN: registers the gf_mul output before it is
// accumulated and adds a one-cycle DRAIN state ahead of OUT.
module gf_matvec_seq
    import gf_pkg::*;
#(
    parameter int N    = GF_N,
    parameter int ROWS = GF_ROWS,
    parameter int COLS = GF_COLS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   p,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [N-1:0]  acc;
    logic [N:0]    p_q;
    logic [N-1:0]  b_mem [COLS];
    logic          done_q;
    logic [N-1:0]  prod;
    logic          in_hs;

`ifdef GF_MATVEC_PIPE_EN
    logic [N-1:0]  prod_q;
    logic          prod_v;
`endif

    // In MAC the multiplier pairs the incoming A element with the b element
    // of the same column; in other states its output is simply unused.
    gf_mul #(.N(N)) u_mul (
        .a (in_data),
        .b (b_mem[col]),
        .p (p_q),
        .s (prod)
    );

    assign in_ready  = (state == ST_LOAD_B) || (state == ST_MAC);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state == ST_OUT);
    assign out_data  = out_valid ? acc : '0;
    assign out_last  = out_valid && (row == ROW_LAST);
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            row    <= '0;
            col    <= '0;
            acc    <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < COLS; i++) b_mem[i] <= '0;
`ifdef GF_MATVEC_PIPE_EN
            prod_q <= '0;
            prod_v <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef GF_MATVEC_PIPE_EN
            prod_v <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        p_q   <= p;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                        state <= ST_LOAD_B;
                    end
                end

                ST_LOAD_B: begin
                    if (in_hs) begin
                        b_mem[col] <= in_data;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            row   <= '0;
                            acc   <= '0;
                            state <= ST_MAC;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end

                ST_MAC: begin
`ifdef GF_MATVEC_PIPE_EN
                    // Product of the previous handshake lands one cycle late.
                    if (prod_v) acc <= acc ^ prod_q;
                    if (in_hs) begin
                        prod_q <= prod;
                        prod_v <= 1'b1;
                    end
`else
                    if (in_hs) acc <= acc ^ prod;
`endif
                    if (in_hs) begin
                        if (col == COL_LAST) begin
                            col <= '0;
`ifdef GF_MATVEC_PIPE_EN
                            state <= ST_DRAIN;
`else
                            state <= ST_OUT;
`endif
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end

`ifdef GF_MATVEC_PIPE_EN
                ST_DRAIN: begin
                    // Fold in the product of the row's final element.
                    if (prod_v) acc <= acc ^ prod_q;
                    state <= ST_OUT;
                end
`endif

                ST_OUT: begin
                    if (out_ready) begin
                        if (row == ROW_LAST) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            row   <= row + RW'(1);
                            acc   <= '0;
                            state <= ST_MAC;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_matvec_seq.sv
// tb_gf_matvec_seq -- directed bench for gf_matvec_seq (N=8, 4x4, p=0x11B).
//
// Expected row sums come from a reference multiplier that forms the full
// 16-bit carry-less product and then reduces it top-down; results are
// queued at job launch and consumed by the output monitor.
module tb_gf_matvec_seq;

`ifdef GF_MATVEC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [8:0] POLY = 9'h11B;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] p;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    gf_matvec_seq #(.N(8), .ROWS(4), .COLS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .p         (p),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_in_cyc = -100;
    int last_hs_cyc = -100;
    int done_cnt    = 0;
    int out_hs_cnt  = 0;
    int jobs_exp    = 0;
    int stall_n     = 0;
    int wait_cnt    = 0;
    bit gap_en      = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] a_m [4][4];
    logic [7:0] b_v [4];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference GF(2^8) multiply: full product, then reduce from the top.
    function automatic logic [7:0] model_mul(input logic [7:0] a, input logic [7:0] b,
                                             input logic [8:0] poly);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) w = w ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--)
            if (w[k]) w = w ^ (16'(poly) << (k - 8));
        return w[7:0];
    endfunction

    function automatic logic [7:0] model_row(input int r);
        logic [7:0] s;
        s = '0;
        for (int c = 0; c < 4; c++) s = s ^ model_mul(a_m[r][c], b_v[c], POLY);
        return s;
    endfunction

    // ---------------- consumer (out_ready policy) ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (wait_cnt < stall_n) begin
                    out_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic       prev_ov = 1'b0;
    logic       holding = 1'b0;
    logic [8:0] held;
    logic [8:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (busy) check("rdy_vld_excl", {31'd0, in_ready & out_valid}, 32'd0);
            if (out_valid && !prev_ov) check("latency", cyc - last_in_cyc, LAT);
            if (out_valid && holding) check("hold_stable", {out_last, out_data}, held);
            if (out_valid && out_ready) begin
                out_hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_last, out_data}, 32'h1FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[7:0]);
                    check("out_last", out_last, e[8]);
                    if (e[8]) last_hs_cyc = cyc;
                end
                holding = 1'b0;
            end else if (out_valid) begin
                holding = 1'b1;
                held    = {out_last, out_data};
            end else begin
                holding = 1'b0;
            end
            if (done) begin
                check("done_timing", cyc, last_hs_cyc + 1);
                check("done_not_busy", busy, 0);
                done_cnt++;
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks (called at posedge+#1) ----------------
    task automatic send(input logic [7:0] d);
        int  waited;
        logic hs;
        if (gap_en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        hs       = 1'b0;
        while (!hs && waited < 200) begin
            @(negedge clk);
            hs = in_ready;
            if (hs) last_in_cyc = cyc;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!hs) check("in_timeout", 0, 1);
    endtask

    task automatic run_job(input bit mid_start, input bit on_done);
        int waited;
        for (int r = 0; r < 4; r++) exp_q.push_back({r == 3, model_row(r)});
        jobs_exp++;
        if (on_done) begin
            // Start in the very cycle done is high.
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done && waited < 500);
            if (!done) check("b2b_done_timeout", 0, 1);
        end
        p     = POLY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        p     = 9'($urandom);
        for (int c = 0; c < 4; c++) send(b_v[c]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                send(a_m[r][c]);
                if (mid_start && r == 1 && c == 1) begin
                    p     = 9'h000;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
    endtask

    task automatic wait_jobs();
        int waited;
        waited = 0;
        while (done_cnt < jobs_exp && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("jobs_done", done_cnt, jobs_exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a_m[r][c] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 4; c++) b_v[c] = 8'($urandom_range(0, 255));
    endtask

    // ---------------- main sequence ----------------
    int saved_done;
    int saved_out;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        p        = 9'h000;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Pin the reference multiplier with hand-computed products.
        check("pin_57x83", model_mul(8'h57, 8'h83, POLY), 8'hC1);
        check("pin_53xCA", model_mul(8'h53, 8'hCA, POLY), 8'h01);
        check("pin_02x87", model_mul(8'h02, 8'h87, POLY), 8'h15);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Job 1: single nonzero product in row 0.
        fill_random();
        a_m[0] = '{8'h57, 8'h00, 8'h00, 8'h00};
        b_v    = '{8'h83, 8'h00, 8'h00, 8'h00};
        check("lit_s0_c1", model_row(0), 8'hC1);
        run_job(1'b0, 1'b0);
        wait_jobs();

        // Job 2: identity, immediately followed by a job started on done.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a_m[r][c] = (r == c) ? 8'h01 : 8'h00;
        b_v = '{8'h01, 8'h02, 8'h03, 8'h04};
        check("lit_ident_s3", model_row(3), 8'h04);
        run_job(1'b0, 1'b0);
        a_m[0] = '{8'h53, 8'h01, 8'h00, 8'h00};
        a_m[1] = '{8'h01, 8'h00, 8'h00, 8'h00};
        a_m[2] = '{8'h00, 8'h01, 8'h00, 8'h00};
        a_m[3] = '{8'h02, 8'h02, 8'h00, 8'h00};
        b_v    = '{8'hCA, 8'hFF, 8'h00, 8'h00};
        check("lit_s0_fe", model_row(0), 8'hFE);
        run_job(1'b0, 1'b1);
        wait_jobs();

        // Output back-pressure and input gaps.
        stall_n = 5;
        gap_en  = 1'b1;
        fill_random();
        run_job(1'b0, 1'b0);
        wait_jobs();
        stall_n = 0;
        fill_random();
        run_job(1'b0, 1'b0);
        wait_jobs();
        gap_en = 1'b0;

        // start pulsed during MAC must be ignored.
        fill_random();
        run_job(1'b1, 1'b0);
        wait_jobs();

        // Reset in the middle of MAC aborts the job.
        fill_random();
        p     = POLY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) send(b_v[c]);
        send(a_m[0][0]);
        send(a_m[0][1]);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        saved_done = done_cnt;
        saved_out  = out_hs_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, saved_done);
        check("abort_no_out",  out_hs_cnt, saved_out);
        check("abort_idle",    busy, 0);

        // Recovery after abort.
        fill_random();
        run_job(1'b0, 1'b0);
        wait_jobs();

        repeat (5) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gf_matvec_seq.md
GF_MATVEC_SEQ -- requirements
Module: gf_matvec_seq

Interface
REQ-001 SHALL have parameter N, default 8, field width in bits, i.e. GF(2^N).
REQ-002 SHALL have parameter ROWS, default 4, number of matrix rows (>=1).
REQ-003 SHALL have parameter COLS, default 4, matrix columns and vector length (>=1).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begins one job; honoured only in IDLE.
REQ-007 SHALL have port p  input  N+1  reduction polynomial; sampled on an accepted start.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data.
REQ-010 SHALL have port in_data  input  N  operand element.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port out_data  output  N  one element of s = A*b.
REQ-014 SHALL have port out_last  output  1  out_data is element ROWS-1.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last out handshake.

Function
REQ-017 SHALL compute s[r] = XOR over c of gfmul(A[r][c], b[c]), with gfmul the carry-less product reduced modulo latched p.
REQ-018 SHALL use exactly one gfmul instance, shared across all products.
REQ-019 SHALL transfer data only on cycles where valid and ready are both high.
REQ-020 SHALL use states IDLE, LOAD_B, MAC, OUT; IDLE + start -> LOAD_B, col=0.
REQ-021 LOAD_B: in_ready=1; each handshake stores b[col]; col++; after element COLS-1 -> MAC with row=0, col=0, acc=0.
REQ-022 MAC: in_ready=1; each handshake takes A[row][col] and sets acc ^= gfmul(in_data, b[col]); after element COLS-1 -> OUT.
REQ-023 OUT: in_ready=0, out_valid=1, out_data=acc, out_last=(row==ROWS-1); out_data and out_last SHALL hold steady until out_ready.
REQ-024 OUT + out_ready: if row<ROWS-1, row++, acc=0, -> MAC; else -> IDLE and pulse done in the next cycle.
REQ-025 Latency from the last row-element handshake to out_valid: 1 cycle (2 with REQ-031).
REQ-026 start outside IDLE SHALL be ignored; start in the same cycle as the done pulse SHALL be accepted.
REQ-027 in_valid without in_ready SHALL have no effect; in_ready and out_valid SHALL never both be high.
REQ-028 p[N]=0 gives undefined data, but the state machine SHALL still complete and never hang.

Reset
REQ-029 While rst_n=0: state=IDLE; row, col, acc, p latch, b storage and all outputs SHALL be 0 (in_ready, out_valid, out_last, busy, done all 0).
REQ-030 rst_n asserted mid-job SHALL abort the job immediately; no partial result or done SHALL follow release.

Configuration
REQ-031 With GF_MATVEC_PIPE_EN defined:
  - gfmul output SHALL be registered one cycle before accumulation.
  - A fifth state DRAIN (in_ready=0, one cycle) SHALL sit between the last MAC handshake and OUT.
  - In MAC, the registered product SHALL be accumulated one cycle after its handshake.
REQ-032 Without GF_MATVEC_PIPE_EN: product SHALL be combinational into acc, and no DRAIN state SHALL exist.

Structure
REQ-033 Package gf_pkg SHALL hold the state enum typedef and the default N, ROWS and COLS constants.
REQ-034 Sub-module gf_mul SHALL be combinational (a[N-1:0], b[N-1:0], p[N:0] -> s[N-1:0]), instantiated once.

Verification
REQ-035 The bench SHALL cover the following directed scenarios (N=8, p=0x11B):
  - A row0=[57,00,00,00], b=[83,00,00,00] -> s[0]=C1; a 4x4 identity A with b=[01,02,03,04] -> s=[01,02,03,04], out_last only on the 4th, done one cycle after.
  - A row=[53,01,00,00], b=[CA,FF,00,00] -> FE (01 XOR FF).
  - out_ready held 0 for 5 cycles in OUT -> out_data stable, in_ready=0, no loss; random in_valid gaps -> same results.
  - start pulsed during MAC -> ignored, results unchanged; rst_n pulsed mid-MAC -> IDLE, all outputs 0, no done.
  - Run with and without GF_MATVEC_PIPE_EN -> identical results; last-element-to-out_valid = 1 vs 2 cycles.
